// File: rtl/mult_div_unit.sv
// Iterative 32-cycle unsigned multiply (shift-add) / divide (restoring) unit
// with HI/LO registers and a direct register-file write port for MFHI/MFLO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_register,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [4:0]       write_register,
  output logic [WIDTH-1:0] write_data,
  output logic             RegWrite
);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MFHI  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [4:0]           count_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   acc_d;

  assign accept    = start && (state_q == IDLE);
  assign last_iter = (count_q == 5'd31);
  assign busy      = (state_q != IDLE);

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc holds {partial remainder, dividend bits becoming quotient}.
  // A zero divisor always "subtracts", giving all-ones quotient and rem = dividend.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_next  = div_ge ? {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign acc_d = (state_q == MUL) ? mul_next : div_next;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && op == OP_MULTU)     state_d = MUL;
        else if (start && op == OP_DIVU) state_d = DIV;
      end
      MUL, DIV: begin
        if (last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        count_q <= '0;
        if (start && op == OP_MULTU) begin
          acc_q  <= {{WIDTH{1'b0}}, operand_b};
          opnd_q <= operand_a;
        end else if (start && op == OP_DIVU) begin
          acc_q  <= {{WIDTH{1'b0}}, operand_a};
          opnd_q <= operand_b;
        end
      end else begin
        acc_q   <= acc_d;
        count_q <= count_q + 5'd1;
        if (last_iter) begin
          hi   <= acc_d[2*WIDTH-1:WIDTH];
          lo   <= acc_d[WIDTH-1:0];
          done <= 1'b1;
        end
      end
    end
  end

  // Move-from HI/LO: one-cycle write strobe; register 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (accept && op[1] && dest_register != 5'd0) begin
      RegWrite       <= 1'b1;
      write_register <= dest_register;
      write_data     <= (op == OP_MFHI) ? hi : lo;
    end else begin
      RegWrite       <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, start
// filtering, MFHI/MFLO write port and asynchronous reset abort.
module tb_mult_div_unit;

  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] DIVU  = 2'b01;
  localparam logic [1:0] MFHI  = 2'b10;
  localparam logic [1:0] MFLO  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_register;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        RegWrite;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .dest_register  (dest_register),
    .busy           (busy),
    .done           (done),
    .hi             (hi),
    .lo             (lo),
    .write_register (write_register),
    .write_data     (write_data),
    .RegWrite       (RegWrite)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one request for exactly one rising edge, then scrambles operands.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    start         = 1'b1;
    op            = o;
    operand_a     = a;
    operand_b     = b;
    dest_register = d;
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // Waits up to 40 edges for done; optionally pokes a MULTU 2*2 request at edge `inject`.
  task automatic wait_done(input int inject, output int cycles, output bit hidden);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0    = hi;
    lo0    = lo;
    cycles = -1;
    hidden = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject) begin
        start     = 1'b1;
        op        = MULTU;
        operand_a = 32'd2;
        operand_b = 32'd2;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        cycles = n;
        break;
      end
      if (hi !== hi0 || lo !== lo0) hidden = 1'b0;
    end
  endtask

  task automatic muldiv(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject, input bit chain);
    int cycles;
    bit hidden;
    issue(o, a, b, 5'd0);
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    wait_done(inject, cycles, hidden);
    check({tag, " latency"}, 64'(cycles), 64'd32);
    check({tag, " hilo_hidden"}, 64'(hidden), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    if (chain) begin
      start     = 1'b1;
      op        = MULTU;
      operand_a = 32'd3;
      operand_b = 32'd5;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " done_cleared"}, 64'(done), 64'd0);
    check({tag, " busy_next"}, 64'(busy), 64'(chain));
  endtask

  initial begin
    int  cycles;
    bit  hidden;

    rst           = 1'b1;
    start         = 1'b0;
    op            = MULTU;
    operand_a     = '0;
    operand_b     = '0;
    dest_register = '0;
    #2;
    check("reset busy_done", {62'd0, busy, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset wport", {26'd0, RegWrite, write_register, write_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    muldiv("mul_7x6", MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 0, 1'b0);

    issue(MFLO, 32'd0, 32'd0, 5'd5);
    check("mflo regwrite", 64'(RegWrite), 64'd1);
    check("mflo wreg", 64'(write_register), 64'd5);
    check("mflo wdata", 64'(write_data), 64'd42);
    check("mflo busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("mflo pulse_end", {26'd0, RegWrite, write_register, write_data}, 64'd0);

    issue(MFHI, 32'd0, 32'd0, 5'd0);
    check("mfhi_r0 wport", {26'd0, RegWrite, write_register, write_data}, 64'd0);

    muldiv("mul_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);

    start         = 1'b1;
    op            = MFHI;
    dest_register = 5'd3;
    @(posedge clk);
    #1;
    check("b2b first", {26'd0, RegWrite, write_register, write_data},
          {26'd0, 1'b1, 5'd3, 32'hFFFF_FFFE});
    op            = MFLO;
    dest_register = 5'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b second", {26'd0, RegWrite, write_register, write_data},
          {26'd0, 1'b1, 5'd4, 32'h0000_0001});
    @(posedge clk);
    #1;
    check("b2b end", 64'(RegWrite), 64'd0);

    muldiv("div_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0);
    muldiv("div_5_0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 1'b0);

    // MULTU 2*2 at edge 10 is ignored; a MULTU 3*5 issued while done=1 is taken.
    muldiv("div_9_3", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 10, 1'b1);
    wait_done(0, cycles, hidden);
    check("chain latency", 64'(cycles), 64'd32);
    check("chain result", {hi, lo}, 64'd15);

    issue(MULTU, 32'd7, 32'd6, 5'd0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid hilo", {hi, lo}, 64'd0);
    check("rst_mid busy_done", {62'd0, busy, done}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    muldiv("rst_restart", MULTU, 32'd3, 32'd3, 32'd0, 32'd9, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (only 32 required).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request strobe, sampled on rising clk.
REQ-005 SHALL have port: op  input  2  00 MULTU, 01 DIVU, 10 MFHI, 11 MFLO.
REQ-006 SHALL have port: operand_a  input  32  multiplicand / dividend.
REQ-007 SHALL have port: operand_b  input  32  multiplier / divisor.
REQ-008 SHALL have port: dest_register  input  5  register-file target for MFHI/MFLO.
REQ-009 SHALL have port: busy  output  1  iterative operation in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, HI/LO just updated.
REQ-011 SHALL have port: hi  output  32  HI register.
REQ-012 SHALL have port: lo  output  32  LO register.
REQ-013 SHALL have ports: write_register (output, 5), write_data (output, 32), RegWrite (output, 1); together these drive the register_file write port directly.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, plus a 5-bit iteration counter.
REQ-015 SHALL accept start only in IDLE; start in MUL/DIV SHALL be ignored, with no queuing and no effect on the running operation.
REQ-016 MULTU/DIVU accepted at edge 0 SHALL:
- set busy=1 after edge 0;
- capture operand_a/operand_b at edge 0, so later operand changes have no effect;
- iterate once per cycle;
- at edge 32: update hi/lo, set busy=0, done=1;
- at edge 33: clear done.
REQ-017 MULTU SHALL use unsigned shift-add: {hi,lo} = operand_a * operand_b, full 64 bits, no truncation.
REQ-018 DIVU SHALL use unsigned restoring division: lo = quotient, hi = remainder.
REQ-019 DIVU with operand_b==0 SHALL still take 32 cycles and yield lo=32'hFFFFFFFF, hi=operand_a.
REQ-020 hi/lo SHALL change only at operation completion or reset; intermediate values SHALL NOT be visible.
REQ-021 A start accepted in the same cycle done=1 (IDLE) SHALL begin a new operation; done still clears at the next edge.
REQ-022 MFHI/MFLO accepted at edge 0 SHALL:
- drive RegWrite=1 for exactly the cycle after edge 0;
- drive write_register=dest_register and write_data=hi (MFHI) or lo (MFLO) as held at edge 0;
- leave busy at 0.
REQ-023 MFHI/MFLO with dest_register==0 SHALL keep RegWrite=0.
REQ-024 Whenever RegWrite=0, write_register and write_data SHALL be 0.
REQ-025 Back-to-back MFHI/MFLO on consecutive cycles SHALL each produce one RegWrite pulse.

Reset
REQ-026 While rst=1, outputs SHALL be immediately: busy=0, done=0, hi=0, lo=0, RegWrite=0, write_register=0, write_data=0; state SHALL be IDLE and counter 0.
REQ-027 rst asserted mid-operation SHALL abort the operation, drop the result, and cause no done pulse.
REQ-028 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 MULTU a=7, b=6 -> busy high 32 cycles; at edge 32 hi=0, lo=42, done pulse 1 cycle.
REQ-030 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-031 DIVU a=100, b=7 -> lo=14, hi=2; then DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
REQ-032 After MULTU 7*6, MFLO dest=5 -> next cycle RegWrite=1, write_register=5, write_data=42; MFHI dest=0 -> RegWrite stays 0.
REQ-033 Start DIVU a=9, b=3; at edge 10 pulse start with MULTU a=b=2 -> ignored; final lo=3, hi=0.
REQ-034 MULTU 7*6, then rst at edge 15 -> hi=lo=0, busy=0, no done pulse; MULTU 3*3 restarted after reset -> lo=9 at 32 cycles.
